// File: rtl/he_core_param.sv
// =============================================================================
// he_core_param : histogram build, CDF + exact divide, streamed equalisation LUT
// Revision 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module he_core_param #(
   parameter int PIX_W      = 8,
   parameter int NUM_PIXELS = 290400,
   parameter int CNT_W      = 19
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] pixel_value,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_index,
   output logic [PIX_W-1:0] transformed_pixel,
   output logic             busy,
   output logic             done
);

   localparam int c_LEVELS  = 1 << PIX_W;
   localparam int c_NUM_W   = CNT_W + PIX_W;
   localparam int c_BIN_CYC = c_NUM_W + 1;
   localparam int c_STEP_W  = $clog2(c_BIN_CYC);

   typedef enum logic [1:0] {
      ST_HIST = 2'd0,
      ST_CDF  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   state_t r_state, w_state_next;

   logic [CNT_W-1:0]    r_hist [c_LEVELS];
   logic [PIX_W-1:0]    r_map  [c_LEVELS];
   logic [CNT_W-1:0]    r_pix_cnt;
   logic                r_ident;
   logic [CNT_W-1:0]    r_cdf;
   logic [CNT_W-1:0]    r_cdf_min;
   logic                r_min_set;
   logic [PIX_W-1:0]    r_bin;
   logic [c_STEP_W-1:0] r_step;
   logic [c_NUM_W-1:0]  r_num;
   logic [CNT_W-1:0]    r_den;
   logic [CNT_W-1:0]    r_rem;
   logic [PIX_W-1:0]    r_quo;
   logic [PIX_W-1:0]    r_out_idx;
   logic                r_done;

   logic                w_accept;
   logic                w_last_pix;
   logic [CNT_W-1:0]    w_hist_inc;
   logic [CNT_W-1:0]    w_bin_cnt;
   logic [CNT_W-1:0]    w_cdf_new;
   logic [CNT_W-1:0]    w_min_new;
   logic [c_NUM_W-1:0]  w_num_init;
   logic [CNT_W-1:0]    w_den_init;
   logic [CNT_W:0]      w_trial;
   logic [CNT_W:0]      w_sub;
   logic                w_fits;
   logic [PIX_W-1:0]    w_quo_next;
   logic                w_last_step;
   logic [PIX_W-1:0]    w_map_val;
   logic                w_cdf_done;
   logic                w_out_fire;
   logic                w_out_last;

   assign w_accept   = in_valid && (r_state == ST_HIST);
   assign w_last_pix = w_accept && (r_pix_cnt == CNT_W'(NUM_PIXELS - 1));
   assign w_hist_inc = r_hist[pixel_value] + CNT_W'(1);

   // First cycle of each bin: running CDF, first non-zero bin latches cdf_min
   assign w_bin_cnt  = r_hist[r_bin];
   assign w_cdf_new  = r_cdf + w_bin_cnt;
   assign w_min_new  = (!r_min_set && (w_bin_cnt != '0)) ? w_bin_cnt : r_cdf_min;
   assign w_num_init = c_NUM_W'(w_cdf_new - w_min_new) * c_NUM_W'(c_LEVELS - 1);
   assign w_den_init = CNT_W'(NUM_PIXELS) - w_min_new;

   // Restoring divide; the quotient always fits PIX_W, so only its low bits are kept
   assign w_trial    = {r_rem, r_num[c_NUM_W-1]};
   assign w_sub      = w_trial - {1'b0, r_den};
   assign w_fits     = (w_trial >= {1'b0, r_den});
   assign w_quo_next = (r_quo << 1) | PIX_W'(w_fits);

   assign w_last_step = (r_step == c_STEP_W'(c_BIN_CYC - 1));
   assign w_map_val   = r_ident ? r_bin : ((r_cdf == '0) ? '0 : w_quo_next);
   assign w_cdf_done  = (r_state == ST_CDF) && w_last_step && (r_bin == PIX_W'(c_LEVELS - 1));
   assign w_out_fire  = (r_state == ST_OUT) && out_ready;
   assign w_out_last  = w_out_fire && (r_out_idx == '1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_HIST;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      in_ready          = 1'b0;
      out_valid         = 1'b0;
      busy              = 1'b0;
      transformed_pixel = '0;
      case (r_state)
         ST_HIST: begin
            in_ready = 1'b1;
            if (w_last_pix) w_state_next = ST_CDF;
         end
         ST_CDF: begin
            busy = 1'b1;
            if (w_cdf_done) w_state_next = ST_OUT;
         end
         ST_OUT: begin
            busy              = 1'b1;
            out_valid         = 1'b1;
            transformed_pixel = r_map[r_out_idx];
            if (w_out_last) w_state_next = ST_HIST;
         end
         default: w_state_next = ST_HIST;
      endcase
   end

   assign out_index = r_out_idx;
   assign done      = r_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < c_LEVELS; i++) r_hist[i] <= '0;
         r_pix_cnt <= '0;
         r_ident   <= 1'b0;
         r_cdf     <= '0;
         r_cdf_min <= '0;
         r_min_set <= 1'b0;
         r_bin     <= '0;
         r_step    <= '0;
         r_num     <= '0;
         r_den     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_out_idx <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_HIST: begin
               if (w_accept) begin
                  r_hist[pixel_value] <= w_hist_inc;
                  r_pix_cnt           <= w_last_pix ? '0 : r_pix_cnt + CNT_W'(1);
                  // A bin holding the whole frame means den will be zero
                  if (w_hist_inc == CNT_W'(NUM_PIXELS)) r_ident <= 1'b1;
               end
            end
            ST_CDF: begin
               if (r_step == '0) begin
                  r_cdf     <= w_cdf_new;
                  r_cdf_min <= w_min_new;
                  if (w_bin_cnt != '0) r_min_set <= 1'b1;
                  r_num     <= w_num_init;
                  r_den     <= w_den_init;
                  r_rem     <= '0;
                  r_quo     <= '0;
                  r_step    <= c_STEP_W'(1);
               end else begin
                  r_num <= r_num << 1;
                  r_rem <= CNT_W'(w_fits ? w_sub : w_trial);
                  r_quo <= w_quo_next;
                  if (w_last_step) begin
                     r_step <= '0;
                     r_bin  <= r_bin + PIX_W'(1);
                  end else begin
                     r_step <= r_step + c_STEP_W'(1);
                  end
               end
            end
            ST_OUT: begin
               if (w_out_fire) r_out_idx <= r_out_idx + PIX_W'(1);
               if (w_out_last) begin
                  r_done <= 1'b1;
                  for (int i = 0; i < c_LEVELS; i++) r_hist[i] <= '0;
                  r_pix_cnt <= '0;
                  r_ident   <= 1'b0;
                  r_cdf     <= '0;
                  r_cdf_min <= '0;
                  r_min_set <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && (r_state == ST_CDF) && (r_step != '0) && w_last_step) begin
         r_map[r_bin] <= w_map_val;
      end
   end

endmodule

`default_nettype wire

// File: doc/he_core_param.md
Name: he_core_param

Overview:
Parametrised histogram-equalisation core, the successor to the fixed 8-bit/660x440 HE block. It accepts one frame of pixels over a valid/ready stream and builds a histogram. It then computes the equalisation mapping with an exact sequential divider and streams out the full 2^PIX_W-entry transformation table with backpressure. The block sits between the pixel source and the mapping/LUT stage, and re-arms automatically for the next frame.

Parameters:
PIX_W, 8, pixel bit width; number of levels L = 2^PIX_W.
NUM_PIXELS, 290400, pixels per frame (660x440); must be >= 1.
CNT_W, 19, histogram/CDF counter width; must satisfy 2^CNT_W > NUM_PIXELS.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  pixel_value is valid this cycle.
in_ready  out  1  block accepts a pixel this cycle; high only in HIST.
pixel_value  in  PIX_W  input pixel.
out_valid  out  1  table entry valid.
out_ready  in  1  consumer accepts the table entry.
out_index  out  PIX_W  table index (source grey level) of the current entry.
transformed_pixel  out  PIX_W  mapped level for out_index.
busy  out  1  high in CDF and OUT.
done  out  1  one-cycle pulse after the last table entry is accepted.

Behaviour:
- Reset (synchronous, active-high): state=HIST, all histogram bins=0, pixel counter=0, in_ready=1, out_valid=0, out_index=0, transformed_pixel=0, busy=0, done=0. Reset in any state, including mid-CDF or mid-OUT, aborts the frame; the table is discarded.
- States: HIST -> CDF -> OUT -> HIST.
- HIST: in_ready=1. Accept on in_valid&in_ready, then hist[pixel_value]++. Repeated identical pixels on consecutive cycles must each count; there is no RMW hazard. in_valid gaps are allowed. When the NUM_PIXELS-th pixel is accepted, go to CDF next cycle, with in_ready=0 from that cycle on.
- CDF: bins are processed in order i=0..L-1, with a fixed cost of D = CNT_W+PIX_W+1 cycles per bin. CDF length is therefore exactly L*D cycles.
  - Cycle 1 of each bin: cdf += hist[i]. If cdf_min is unset and hist[i] != 0, set cdf_min = hist[i].
  - Remaining CNT_W+PIX_W cycles: restoring division, one quotient bit per cycle.
  - num = (cdf - cdf_min)*(L-1), width CNT_W+PIX_W. den = NUM_PIXELS - cdf_min.
  - map[i] = floor(num/den), truncation with no rounding. The result always fits in PIX_W.
  - If cdf == 0 (before the first populated bin): map[i] = 0.
  - If den == 0 (single-valued frame): map[i] = i for all i (identity). This is decided per frame and must not cause a divide-by-zero.
  - Results go into an internal L x PIX_W table.
  - After bin L-1, go to OUT.
- OUT: entries are presented for index 0..L-1 in order.
  - out_valid=1, out_index=k, transformed_pixel=map[k].
  - Advance only on out_valid&out_ready. While stalled, all out_* signals stay stable.
  - After entry L-1 is accepted: out_valid=0 and done=1 for exactly one cycle. In that same cycle the state is HIST, all bins and cdf/cdf_min/counter are cleared, and in_ready=1, so a new frame may start immediately.
- busy = (state==CDF or OUT). in_ready and out_valid are never high together.
- Width rules: all arithmetic is unsigned. No counter or CDF can overflow given 2^CNT_W > NUM_PIXELS.

Test Plan:
1. PIX_W=4, NUM_PIXELS=16, CNT_W=5; pixels 0..15 once each -> CDF lasts exactly 16*10=160 cycles; map[i]=floor((i+1-1)*15/15)=i for i=0..15; done pulses once.
2. Defaults; all 290400 pixels = 8'd7 -> den=0 path; map[k]=k for k=0..255; no X on transformed_pixel.
3. PIX_W=8, NUM_PIXELS=8, CNT_W=4; pixels 10,10,10,10,200,200,200,200 -> map[0..199]=0, map[200..255]=floor(4*255/4)=255.
4. Case 3 with random in_valid gaps and out_ready low for 3 cycles at k=200 -> identical table; out_index and transformed_pixel held at 200/255 while stalled; in_ready=0 after pixel 8.
5. Assert reset mid-CDF (bin 100), then run frame 1 -> in_ready=1 the cycle after reset; the frame 1 table matches a clean run.
6. Run case 1 and a descending frame (15..0) back-to-back -> second frame accepted starting in the done cycle; second table is again the identity; exactly two done pulses.
